// File: rtl/osecpu_pkg.sv
// Shared definitions for the osecpu sequencer: opcodes, FSM encoding and
// instruction field positions.
package osecpu_pkg;

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_LIMM16 = 8'h02;
    localparam logic [7:0] OP_JMP    = 8'h04;
    localparam logic [7:0] OP_JNZ    = 8'h05;
    localparam logic [7:0] OP_CP     = 8'h10;
    localparam logic [7:0] OP_ADD    = 8'h14;
    localparam logic [7:0] OP_SUB    = 8'h15;
    localparam logic [7:0] OP_HALT   = 8'hFF;

    localparam int F_OP_HI  = 31;
    localparam int F_OP_LO  = 24;
    localparam int F_OP0_HI = 23;
    localparam int F_OP0_LO = 18;
    localparam int F_OP1_HI = 17;
    localparam int F_OP1_LO = 12;
    localparam int F_OP2_HI = 11;
    localparam int F_OP2_LO = 6;
    localparam int F_IMM_HI = 15;
    localparam int F_IMM_LO = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    function automatic logic op_writes(input logic [7:0] op);
        return (op == OP_LIMM16) || (op == OP_CP) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

    function automatic logic op_known(input logic [7:0] op);
        return op_writes(op) || (op == OP_NOP) || (op == OP_JMP) ||
               (op == OP_JNZ) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/osecpu_alu.sv
// Combinational datapath: register-write result for the writing opcodes and
// the zero test that decides a JNZ.
module osecpu_alu
    import osecpu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [7:0]        i_op,
    input  logic [15:0]       i_imm16,
    input  logic [DATA_W-1:0] i_d0,
    input  logic [DATA_W-1:0] i_d1,
    output logic [DATA_W-1:0] o_result,
    output logic              o_zero
);

    always_comb begin
        o_result = '0;
        case (i_op)
            OP_LIMM16: o_result = {{(DATA_W-16){i_imm16[15]}}, i_imm16};
            OP_CP:     o_result = i_d0;
            OP_ADD:    o_result = i_d0 + i_d1;
            OP_SUB:    o_result = i_d0 - i_d1;
            default:   o_result = '0;
        endcase
    end

    assign o_zero = (i_d0 == '0);

endmodule

// File: rtl/core_sequencer.sv
// Three-cycle fetch/load/execute sequencer: fetches from a synchronous
// instruction memory and drives an external two-read/one-write register file.
module core_sequencer
    import osecpu_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int RIDX_W = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              run,
    input  logic              single_step,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [RIDX_W-1:0] ireg_r0,
    output logic [RIDX_W-1:0] ireg_r1,
    input  logic [DATA_W-1:0] ireg_d0,
    input  logic [DATA_W-1:0] ireg_d1,
    output logic [RIDX_W-1:0] ireg_rw,
    output logic [DATA_W-1:0] ireg_dw,
    output logic              ireg_we,
    output logic [ADDR_W-1:0] pc,
    output logic [7:0]        cur_op,
    output logic              halted,
    output logic              illegal
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_instr;
    logic              r_we;
    logic              r_halted;
    logic              r_illegal;

    logic [7:0]        w_op;
    logic [5:0]        w_op0;
    logic [5:0]        w_op1;
    logic [5:0]        w_op2;
    logic [15:0]       w_imm16;
    logic [ADDR_W-1:0] w_jmp_pc;
    logic [7:0]        w_load_op;
    logic              w_zero;
    logic [DATA_W-1:0] w_result;

    assign w_op      = r_instr[F_OP_HI:F_OP_LO];
    assign w_op0     = r_instr[F_OP0_HI:F_OP0_LO];
    assign w_op1     = r_instr[F_OP1_HI:F_OP1_LO];
    assign w_op2     = r_instr[F_OP2_HI:F_OP2_LO];
    assign w_imm16   = r_instr[F_IMM_HI:F_IMM_LO];
    assign w_jmp_pc  = ADDR_W'(w_imm16);
    assign w_load_op = mem_rdata[F_OP_HI:F_OP_LO];

    osecpu_alu #(.DATA_W(DATA_W)) u_alu (
        .i_op     (w_op),
        .i_imm16  (w_imm16),
        .i_d0     (ireg_d0),
        .i_d1     (ireg_d1),
        .o_result (w_result),
        .o_zero   (w_zero)
    );

    // JNZ tests its destination field, so port 0 is steered to op0 for it.
    assign ireg_r0  = (w_op == OP_JNZ) ? RIDX_W'(w_op0) : RIDX_W'(w_op1);
    assign ireg_r1  = RIDX_W'(w_op2);
    assign ireg_rw  = RIDX_W'(w_op0);
    assign ireg_dw  = w_result;
    assign ireg_we  = r_we;
    assign mem_addr = r_pc;
    assign pc       = r_pc;
    assign cur_op   = w_op;
    assign halted   = r_halted;
    assign illegal  = r_illegal;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_pc      <= '0;
            r_instr   <= '0;
            r_we      <= 1'b0;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (run) r_state <= ST_FETCH;
                end
                ST_FETCH: begin
                    r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_instr <= mem_rdata;
                    r_pc    <= r_pc + ADDR_W'(1);
                    // Write enable is armed here so it is high for exactly the EXEC cycle.
                    r_we    <= op_writes(w_load_op);
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    r_we <= 1'b0;
                    if ((w_op == OP_HALT) || !op_known(w_op)) begin
                        r_state   <= ST_HALT;
                        r_halted  <= 1'b1;
                        r_illegal <= !op_known(w_op);
                    end else begin
                        if ((w_op == OP_JMP) || ((w_op == OP_JNZ) && !w_zero))
                            r_pc <= w_jmp_pc;
                        r_state <= single_step ? ST_IDLE : ST_FETCH;
                    end
                end
                ST_HALT: begin
                    if (run) begin
                        r_state   <= ST_FETCH;
                        r_pc      <= '0;
                        r_halted  <= 1'b0;
                        r_illegal <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_we    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboarded bench for core_sequencer: programs are loaded into a model
// memory, expected register writes queued, and observed writes compared.
module tb_core_sequencer;

    logic        clk;
    logic        reset_n;
    logic        run;
    logic        single_step;
    logic [15:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [5:0]  ireg_r0, ireg_r1, ireg_rw;
    logic [31:0] ireg_d0, ireg_d1, ireg_dw;
    logic        ireg_we;
    logic [15:0] pc;
    logic [7:0]  cur_op;
    logic        halted;
    logic        illegal;

    typedef struct packed {
        logic [5:0]  rw;
        logic [31:0] dw;
    } wr_t;

    wr_t exp_q[$];
    wr_t obs_q[$];
    int  checks = 0;
    int  errors = 0;

    logic [31:0] mem [0:65535];
    logic [31:0] rf  [0:63];

    core_sequencer #(.ADDR_W(16), .DATA_W(32), .RIDX_W(6)) dut (
        .clk(clk), .reset_n(reset_n), .run(run), .single_step(single_step),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .ireg_r0(ireg_r0), .ireg_r1(ireg_r1), .ireg_d0(ireg_d0), .ireg_d1(ireg_d1),
        .ireg_rw(ireg_rw), .ireg_dw(ireg_dw), .ireg_we(ireg_we),
        .pc(pc), .cur_op(cur_op), .halted(halted), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) mem_rdata <= mem[mem_addr];
    always @(posedge clk) if (ireg_we) rf[ireg_rw] <= ireg_dw;
    assign ireg_d0 = rf[ireg_r0];
    assign ireg_d1 = rf[ireg_r1];

    always @(negedge clk) if (ireg_we) obs_q.push_back(wr_t'({ireg_rw, ireg_dw}));

    function automatic logic [31:0] enc_r(input logic [7:0] op, input logic [5:0] a,
                                          input logic [5:0] b, input logic [5:0] c);
        return {op, a, b, c, 6'b000000};
    endfunction

    function automatic logic [31:0] enc_i(input logic [7:0] op, input logic [5:0] a,
                                          input logic [15:0] imm);
        return {op, a, 2'b00, imm};
    endfunction

    task automatic pulse_run();
        @(negedge clk) run = 1'b1;
        @(negedge clk) run = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        checks++; if (pc !== 16'h0)      begin errors++; $display("FAIL rst_pc got %h exp 0000", pc); end
        checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL rst_addr got %h exp 0000", mem_addr); end
        checks++; if (cur_op !== 8'h00)   begin errors++; $display("FAIL rst_cur_op got %h exp 00", cur_op); end
        checks++; if (ireg_we !== 1'b0)   begin errors++; $display("FAIL rst_we got %b exp 0", ireg_we); end
        checks++; if (halted !== 1'b0)    begin errors++; $display("FAIL rst_halted got %b exp 0", halted); end
        checks++; if (illegal !== 1'b0)   begin errors++; $display("FAIL rst_illegal got %b exp 0", illegal); end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        checks++; if (pc !== 16'h0) begin errors++; $display("FAIL idle_no_run_pc got %h exp 0000", pc); end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL idle_no_run_writes got %0d exp 0", obs_q.size()); end
    endtask

    task automatic test_basic();
        mem[0] = 32'h02040005;
        mem[1] = enc_r(8'hFF, 6'd0, 6'd0, 6'd0);
        exp_q.push_back(wr_t'({6'd1, 32'h00000005}));
        pulse_run();
        checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL basic_fetch_addr got %h exp 0000", mem_addr); end
        repeat (2) @(negedge clk);
        checks++; if ({ireg_we, ireg_rw, ireg_dw} !== {1'b1, 6'd1, 32'h5})
            begin errors++; $display("FAIL basic_cycle3 got we=%b rw=%0d dw=%h exp we=1 rw=1 dw=00000005", ireg_we, ireg_rw, ireg_dw); end
        repeat (3) @(negedge clk);
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL basic_halt_early got %b exp 0", halted); end
        @(negedge clk);
        checks++; if ({halted, illegal, pc, cur_op} !== {1'b1, 1'b0, 16'h2, 8'hFF})
            begin errors++; $display("FAIL basic_halt got h=%b i=%b pc=%h op=%h exp h=1 i=0 pc=0002 op=ff", halted, illegal, pc, cur_op); end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_sb_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            wr_t e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL basic_sb got rw=%0d dw=%h exp rw=%0d dw=%h", o.rw, o.dw, e.rw, e.dw); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_limm_sign();
        int n;
        mem[0] = enc_i(8'h02, 6'd2, 16'h8000);
        mem[1] = enc_i(8'h02, 6'd3, 16'h7FFF);
        mem[2] = enc_r(8'hFF, 6'd0, 6'd0, 6'd0);
        exp_q.push_back(wr_t'({6'd2, 32'hFFFF8000}));
        exp_q.push_back(wr_t'({6'd3, 32'h00007FFF}));
        pulse_run();
        n = 0;
        while (!halted && n < 300) begin @(negedge clk); n++; end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL limm_timeout got halted=%b exp 1", halted); end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL limm_sb_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            wr_t e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL limm_sb got rw=%0d dw=%h exp rw=%0d dw=%h", o.rw, o.dw, e.rw, e.dw); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_add_jnz();
        int n;
        mem[0]     = enc_i(8'h02, 6'd1, 16'hFFFF);
        mem[1]     = enc_i(8'h02, 6'd2, 16'h0001);
        mem[2]     = enc_r(8'h14, 6'd3, 6'd1, 6'd2);
        mem[3]     = enc_i(8'h05, 6'd3, 16'h0010);
        mem[4]     = enc_i(8'h02, 6'd4, 16'h0003);
        mem[5]     = enc_i(8'h05, 6'd4, 16'h0010);
        mem[6]     = enc_i(8'h02, 6'd5, 16'h0077);
        mem[7]     = enc_r(8'hFF, 6'd0, 6'd0, 6'd0);
        mem[16'h10] = enc_r(8'h15, 6'd6, 6'd4, 6'd2);
        mem[16'h11] = enc_r(8'h15, 6'd7, 6'd2, 6'd1);
        mem[16'h12] = enc_r(8'h10, 6'd8, 6'd6, 6'd0);
        mem[16'h13] = enc_r(8'hFF, 6'd0, 6'd0, 6'd0);
        exp_q.push_back(wr_t'({6'd1, 32'hFFFFFFFF}));
        exp_q.push_back(wr_t'({6'd2, 32'h00000001}));
        exp_q.push_back(wr_t'({6'd3, 32'h00000000}));
        exp_q.push_back(wr_t'({6'd4, 32'h00000003}));
        exp_q.push_back(wr_t'({6'd6, 32'h00000002}));
        exp_q.push_back(wr_t'({6'd7, 32'h00000002}));
        exp_q.push_back(wr_t'({6'd8, 32'h00000002}));
        pulse_run();
        for (int c = 2; c <= 19; c++) begin
            @(negedge clk);
            if (c == 13) begin
                checks++; if (mem_addr !== 16'h0004) begin errors++; $display("FAIL jnz_not_taken got %h exp 0004", mem_addr); end
            end
            if (c == 19) begin
                checks++; if (mem_addr !== 16'h0010) begin errors++; $display("FAIL jnz_taken got %h exp 0010", mem_addr); end
            end
        end
        n = 0;
        while (!halted && n < 300) begin @(negedge clk); n++; end
        checks++; if ({halted, pc} !== {1'b1, 16'h0014}) begin errors++; $display("FAIL addjnz_halt got h=%b pc=%h exp h=1 pc=0014", halted, pc); end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL addjnz_sb_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            wr_t e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL addjnz_sb got rw=%0d dw=%h exp rw=%0d dw=%h", o.rw, o.dw, e.rw, e.dw); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_illegal();
        int n;
        mem[0] = 32'h7E040001;
        mem[1] = enc_r(8'hFF, 6'd0, 6'd0, 6'd0);
        pulse_run();
        n = 0;
        while (!halted && n < 300) begin @(negedge clk); n++; end
        checks++; if ({halted, illegal, cur_op, pc} !== {1'b1, 1'b1, 8'h7E, 16'h0001})
            begin errors++; $display("FAIL illegal_halt got h=%b i=%b op=%h pc=%h exp h=1 i=1 op=7e pc=0001", halted, illegal, cur_op, pc); end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL illegal_no_write got %0d exp 0", obs_q.size()); end
        single_step = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if ({halted, pc} !== {1'b1, 16'h0001}) begin errors++; $display("FAIL halt_step_ignored got h=%b pc=%h exp h=1 pc=0001", halted, pc); end
        single_step = 1'b0;
        pulse_run();
        checks++; if ({mem_addr, illegal, halted} !== {16'h0000, 1'b0, 1'b0})
            begin errors++; $display("FAIL illegal_restart got addr=%h i=%b h=%b exp addr=0000 i=0 h=0", mem_addr, illegal, halted); end
        n = 0;
        while (!halted && n < 300) begin @(negedge clk); n++; end
        checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_again got %b exp 1", illegal); end
        obs_q.delete();
    endtask

    task automatic test_single_step();
        int n;
        mem[0] = enc_i(8'h02, 6'd1, 16'h0011);
        mem[1] = enc_i(8'h02, 6'd2, 16'h0022);
        mem[2] = enc_r(8'hFF, 6'd0, 6'd0, 6'd0);
        exp_q.push_back(wr_t'({6'd1, 32'h00000011}));
        exp_q.push_back(wr_t'({6'd2, 32'h00000022}));
        single_step = 1'b1;
        pulse_run();
        repeat (2) @(negedge clk);
        checks++; if (ireg_we !== 1'b1) begin errors++; $display("FAIL step1_we got %b exp 1", ireg_we); end
        repeat (6) @(negedge clk);
        checks++; if ({halted, pc, 6'(obs_q.size())} !== {1'b0, 16'h0001, 6'd1})
            begin errors++; $display("FAIL step1_idle got h=%b pc=%h writes=%0d exp h=0 pc=0001 writes=1", halted, pc, obs_q.size()); end
        pulse_run();
        repeat (8) @(negedge clk);
        checks++; if ({halted, pc, 6'(obs_q.size())} !== {1'b0, 16'h0002, 6'd2})
            begin errors++; $display("FAIL step2_idle got h=%b pc=%h writes=%0d exp h=0 pc=0002 writes=2", halted, pc, obs_q.size()); end
        pulse_run();
        n = 0;
        while (!halted && n < 300) begin @(negedge clk); n++; end
        checks++; if ({halted, illegal, pc} !== {1'b1, 1'b0, 16'h0003})
            begin errors++; $display("FAIL step3_halt got h=%b i=%b pc=%h exp h=1 i=0 pc=0003", halted, illegal, pc); end
        single_step = 1'b0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            wr_t e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL step_sb got rw=%0d dw=%h exp rw=%0d dw=%h", o.rw, o.dw, e.rw, e.dw); end
        end
        checks++; if (exp_q.size() != obs_q.size()) begin errors++; $display("FAIL step_sb_left got %0d exp %0d", obs_q.size(), exp_q.size()); end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid_and_wrap();
        mem[0] = enc_i(8'h02, 6'd1, 16'h0005);
        mem[1] = enc_i(8'h02, 6'd2, 16'h0006);
        mem[2] = enc_r(8'h14, 6'd3, 6'd1, 6'd2);
        mem[3] = enc_r(8'hFF, 6'd0, 6'd0, 6'd0);
        exp_q.push_back(wr_t'({6'd1, 32'h00000005}));
        exp_q.push_back(wr_t'({6'd2, 32'h00000006}));
        pulse_run();
        repeat (8) @(posedge clk);
        #2;
        checks++; if ({ireg_we, ireg_rw, ireg_dw} !== {1'b1, 6'd3, 32'd11})
            begin errors++; $display("FAIL add_exec got we=%b rw=%0d dw=%h exp we=1 rw=3 dw=0000000b", ireg_we, ireg_rw, ireg_dw); end
        reset_n = 1'b0;
        #1;
        checks++; if ({ireg_we, pc, halted} !== {1'b0, 16'h0000, 1'b0})
            begin errors++; $display("FAIL mid_reset got we=%b pc=%h h=%b exp we=0 pc=0000 h=0", ireg_we, pc, halted); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL mid_reset_idle got pc=%h exp 0000", pc); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            wr_t e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL mid_sb got rw=%0d dw=%h exp rw=%0d dw=%h", o.rw, o.dw, e.rw, e.dw); end
        end
        checks++; if (exp_q.size() != obs_q.size()) begin errors++; $display("FAIL mid_sb_left got %0d exp %0d", obs_q.size(), exp_q.size()); end
        exp_q.delete(); obs_q.delete();

        mem[0]      = enc_i(8'h04, 6'd0, 16'hFFFF);
        mem[16'hFFFF] = 32'h00000000;
        pulse_run();
        repeat (3) @(negedge clk);
        checks++; if (mem_addr !== 16'hFFFF) begin errors++; $display("FAIL jmp_ffff got %h exp ffff", mem_addr); end
        repeat (2) @(negedge clk);
        checks++; if ({pc, cur_op} !== {16'h0000, 8'h00}) begin errors++; $display("FAIL pc_wrap got pc=%h op=%h exp pc=0000 op=00", pc, cur_op); end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL wrap_no_write got %0d exp 0", obs_q.size()); end
        reset_n = 1'b0;
        #1 reset_n = 1'b1;
    endtask

    initial begin
        run = 1'b0;
        single_step = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
        test_reset();
        test_basic();
        test_limm_sign();
        test_add_jnz();
        test_illegal();
        test_single_step();
        test_reset_mid_and_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning program-counter and memory-address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning instruction, memory and register width (minimum 32).
REQ-003 SHALL have parameter RIDX_W, default 6, meaning register-index width.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port run, input, 1, start or continue request.
REQ-007 SHALL have port single_step, input, 1, which when high returns to IDLE after each instruction.
REQ-008 SHALL have port mem_addr, output, ADDR_W, instruction fetch address.
REQ-009 SHALL have port mem_rdata, input, DATA_W, synchronous memory data, valid one cycle after mem_addr.
REQ-010 SHALL have ports ireg_r0 and ireg_r1, output, RIDX_W, register read indexes (combinational read).
REQ-011 SHALL have ports ireg_d0 and ireg_d1, input, DATA_W, register read data.
REQ-012 SHALL have ports ireg_rw (output, RIDX_W), ireg_dw (output, DATA_W) and ireg_we (output, 1), the register write port.
REQ-013 SHALL have port pc, output, ADDR_W, current program counter.
REQ-014 SHALL have port cur_op, output, 8, opcode of the last latched instruction, for the 7-seg display.
REQ-015 SHALL have ports halted (output, 1, in HALT) and illegal (output, 1, HALT was caused by an unknown opcode).

Function
REQ-016 States SHALL be IDLE, FETCH, LOAD, EXEC and HALT.
- IDLE->FETCH when run=1.
- FETCH->LOAD unconditionally.
- LOAD->EXEC unconditionally.
- EXEC->HALT on HALT opcode or an unknown opcode.
- Otherwise EXEC->IDLE if single_step=1, else EXEC->FETCH.
REQ-017 In FETCH, mem_addr SHALL equal pc; in LOAD, instr SHALL be latched from mem_rdata and pc SHALL become pc+1 modulo 2^ADDR_W (0xFFFF wraps to 0x0000).
REQ-018 Instruction fields SHALL be: op [31:24], op0 [23:18], op1 [17:12], op2 [11:6], imm16 [15:0].
REQ-019 In EXEC, ireg_r0 SHALL be op1 and ireg_r1 SHALL be op2, except for JNZ, where ireg_r0 SHALL be op0.
REQ-020 ireg_we SHALL be high for exactly the EXEC cycle of a writing opcode and low in every other state.
REQ-021 Opcodes SHALL behave as follows (results truncated to DATA_W):
- 0x00 NOP: no effect.
- 0x02 LIMM16: R[op0] = sign-extended imm16.
- 0x10 CP: R[op0] = R[op1].
- 0x14 ADD: R[op0] = R[op1] + R[op2].
- 0x15 SUB: R[op0] = R[op1] - R[op2].
- 0x04 JMP: pc = imm16[ADDR_W-1:0] (zero-extended if ADDR_W > 16).
- 0x05 JNZ: pc = imm16 if R[op0] != 0, else pc unchanged.
- 0xFF HALT.
REQ-022 A JMP or JNZ pc write in EXEC SHALL override the LOAD increment; every instruction SHALL take exactly 3 cycles.
REQ-023 An unknown opcode SHALL set illegal=1, enter HALT and write no register.
REQ-024 In HALT, run=1 SHALL restart at pc=0 via FETCH and clear illegal; single_step SHALL have no effect in HALT.
REQ-025 run SHALL be sampled only in IDLE and HALT.

Reset
REQ-026 When reset_n=0, outputs SHALL immediately and asynchronously be: state IDLE, pc=0, instr=0, cur_op=0x00, ireg_we=0, halted=0, illegal=0.
REQ-027 Reset asserted mid-instruction SHALL abort it, including suppressing any pending ireg_we.
REQ-028 After reset_n rises, execution SHALL begin only on run=1.

Structure
REQ-029 Package osecpu_pkg SHALL hold the opcode constants, the state encoding and the field bit positions.
REQ-030 Sub-module osecpu_alu SHALL be a combinational unit computing the LIMM16, CP, ADD and SUB result and the JNZ zero test.

Verification
REQ-031 Program 0x02040005 at pc 0, then HALT, run pulse -> ireg_we high in cycle 3 with rw=1, dw=0x00000005; halted after 6 cycles; pc=2.
REQ-032 LIMM16 imm 0x8000 -> dw=0xFFFF8000.
REQ-033 ADD with R1=0xFFFFFFFF and R2=1 -> dw=0x00000000; JNZ on R=0 -> pc continues +1; JNZ on R=3 with imm 0x0010 -> next mem_addr=0x0010.
REQ-034 Opcode 0x7E -> halted=1, illegal=1, no ireg_we; run then gives mem_addr=0 and illegal=0.
REQ-035 single_step=1 -> each run pulse executes one instruction (3 cycles) and returns to IDLE.
REQ-036 reset_n dropped during EXEC of an ADD -> ireg_we low immediately, pc=0, state IDLE; JMP 0xFFFF then NOP -> pc wraps to 0x0000.
